multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst; all state changes on rising clk.
REQ-002 Parameter: INSTR_W, 32, instruction width.
REQ-003 Parameter: OP_LSB, 26, opcode field LSB; opcode is instr[OP_LSB+5:OP_LSB].
REQ-004 Parameter: CNT_W, 16, retired-instruction counter width.
REQ-005 Ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- run  in  1  allow fetching
- mem_rdata  in  INSTR_W  instruction word from memory
- mem_ready  in  1  memory completes the current request
- zero  in  1  ALU zero flag
- mem_req  out  1  memory request
- ir_we  out  1  instruction register load strobe
- pc_we  out  1  PC write strobe
- Jump, Branch, Bne, MemtoReg, MemWrite, source, RegWrite, instruction_check  out  1 each  datapath controls
- Operation  out  2  ALU op class
- pc_src  out  1  0=PC+4, 1=branch/jump target
- illegal  out  1  trap flag
- instr_done  out  1  retire pulse
- instr_count  out  CNT_W  retired-instruction count

Function
REQ-006 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP, held in a registered state variable; ir is a registered INSTR_W copy of mem_rdata.
REQ-007 IDLE -> FETCH when run=1; otherwise remain in IDLE; mem_ready SHALL be ignored in IDLE.
REQ-008 FETCH behaviour:
- mem_req=1 every cycle.
- On mem_ready=1: ir_we=1, ir<=mem_rdata, pc_we=1 with pc_src=0, next state DECODE.
- Otherwise hold FETCH.
REQ-009 DECODE SHALL classify ir opcode. Opcodes 000000 R, 000010 J, 001100 ANDI, 101011 SW, 100011 LW, 001000 ADDI, 000100 BEQ and 000101 BNE go to EXEC; any other opcode goes to TRAP.
REQ-010 From DECODE through the instruction's last state, SHALL drive Jump, Branch, Bne, MemtoReg, source, Operation, instruction_check from ir:
- R: Operation=10, source=0, instruction_check=0.
- J: Jump=1, Operation=01.
- ANDI: source=1, Operation=11.
- SW, ADDI: source=1, Operation=00.
- LW: source=1, MemtoReg=1, Operation=00.
- BEQ: Branch=1, Operation=01.
- BNE: Branch=1, Bne=1, Operation=01.
- instruction_check=1 for all non-R opcodes.
- In IDLE, FETCH and TRAP these outputs SHALL be 0.
REQ-011 EXEC next state: R/ADDI/ANDI -> WB; LW/SW -> MEM; J/BEQ/BNE -> end.
REQ-012 EXEC, J: pc_we=1, pc_src=1.
REQ-013 EXEC, BEQ: pc_we=pc_src=1 iff zero=1. EXEC, BNE: pc_we=pc_src=1 iff zero=0. zero SHALL be sampled only in EXEC.
REQ-014 MEM behaviour:
- mem_req=1; MemWrite=1 only for SW.
- Hold until mem_ready=1, then LW -> WB and SW -> end.
REQ-015 WB SHALL assert RegWrite=1 for exactly one cycle, then go to end.
REQ-016 RegWrite, MemWrite and pc_we SHALL be 0 in every state not listed above.
REQ-017 Instruction end (last state of an instruction):
- instr_done=1 for that cycle.
- instr_count increments, wrapping from 2^CNT_W-1 to 0.
- Next state FETCH if run=1, else IDLE.
REQ-018 TRAP: illegal=1, all strobes 0, absorbing until rst; illegal instruction is not counted.
REQ-019 Latency with mem_ready tied 1: R/ADDI/ANDI 4 cycles; LW 5; SW 4; J/BEQ/BNE 3. Each mem_ready-low cycle in FETCH/MEM adds 1.

Reset
REQ-020 rst=1 at a clock edge SHALL force state=IDLE, ir=0 and instr_count=0 at any point, including mid-instruction and in TRAP.
REQ-021 While in IDLE after reset, all outputs SHALL be 0.
REQ-022 A reset during MEM/WB SHALL produce no further MemWrite/RegWrite.

Structure
REQ-023 Opcode constants, the Operation encodings and the state encoding SHALL live in a shared package, bubble_ctrl_pkg.
REQ-024 Opcode-to-control decode SHALL be a combinational sub-module, ctrl_decode, instantiated once and fed from ir.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- R-type 0x012A4020, mem_ready=1 -> DECODE Operation=10; RegWrite only in cycle 4; instr_done in cycle 4; instr_count=1.
- LW 0x8D090004, mem_ready low 3 cycles in MEM -> MemtoReg=1; mem_req held 4 MEM cycles; RegWrite one cycle after mem_ready; total 8 cycles.
- BEQ 0x11090003: zero=1 -> pc_we=pc_src=1 in EXEC. BNE 0x15090003: zero=1 -> pc_we=0. Both 3 cycles.
- Opcode 111111 -> TRAP, illegal=1 held, instr_count unchanged; rst -> IDLE, illegal=0.
- rst asserted in MEM of SW 0xAD090008 -> next cycle state IDLE, MemWrite=0, instr_count=0.
- CNT_W=4, 16 back-to-back ADDI -> instr_count wraps 15 -> 0; run=0 at the last end -> IDLE.

Source files
------------

// File: rtl/bubble_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU op classes,
// FSM states and the decoded-control bundle passed from ctrl_decode to the FSM.
package bubble_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_AND   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    // Which tail of the state sequence follows EXEC.
    typedef enum logic [1:0] {
        SEQ_ALU   = 2'd0,
        SEQ_LOAD  = 2'd1,
        SEQ_STORE = 2'd2,
        SEQ_FLOW  = 2'd3
    } seq_t;

    typedef struct packed {
        logic       valid;
        seq_t       seq;
        logic       jump;
        logic       branch;
        logic       bne;
        logic       mem_to_reg;
        logic       mem_write;
        logic       source;
        logic       instr_check;
        logic [1:0] operation;
    } ctrl_t;

    function automatic logic branch_taken(input logic bne, input logic zero);
        return bne ? ~zero : zero;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder; unknown opcodes yield an all-zero bundle
// with valid=0 so the FSM can divert to TRAP.
module ctrl_decode
    import bubble_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl             = '0;
        o_ctrl.seq         = SEQ_ALU;
        o_ctrl.valid       = 1'b1;
        o_ctrl.instr_check = 1'b1;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.operation   = ALU_FUNCT;
                o_ctrl.instr_check = 1'b0;
            end
            OP_J: begin
                o_ctrl.seq       = SEQ_FLOW;
                o_ctrl.jump      = 1'b1;
                o_ctrl.operation = ALU_SUB;
            end
            OP_ANDI: begin
                o_ctrl.source    = 1'b1;
                o_ctrl.operation = ALU_AND;
            end
            OP_SW: begin
                o_ctrl.seq       = SEQ_STORE;
                o_ctrl.source    = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.operation = ALU_ADD;
            end
            OP_LW: begin
                o_ctrl.seq        = SEQ_LOAD;
                o_ctrl.source     = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.operation  = ALU_ADD;
            end
            OP_ADDI: begin
                o_ctrl.source    = 1'b1;
                o_ctrl.operation = ALU_ADD;
            end
            OP_BEQ: begin
                o_ctrl.seq       = SEQ_FLOW;
                o_ctrl.branch    = 1'b1;
                o_ctrl.operation = ALU_SUB;
            end
            OP_BNE: begin
                o_ctrl.seq       = SEQ_FLOW;
                o_ctrl.branch    = 1'b1;
                o_ctrl.bne       = 1'b1;
                o_ctrl.operation = ALU_SUB;
            end
            default: begin
                o_ctrl     = '0;
                o_ctrl.seq = SEQ_ALU;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: fetches into ir, walks DECODE/EXEC/MEM/WB,
// counts retired instructions and parks in TRAP on an unknown opcode.
module multicycle_control
    import bubble_ctrl_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int OP_LSB  = 26,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               mem_req,
    output logic               ir_we,
    output logic               pc_we,
    output logic               Jump,
    output logic               Branch,
    output logic               Bne,
    output logic               MemtoReg,
    output logic               MemWrite,
    output logic               source,
    output logic               RegWrite,
    output logic               instruction_check,
    output logic [1:0]         Operation,
    output logic               pc_src,
    output logic               illegal,
    output logic               instr_done,
    output logic [CNT_W-1:0]   instr_count
);

    state_t             r_state;
    state_t             w_state_next;
    logic [INSTR_W-1:0] r_ir;
    logic [CNT_W-1:0]   r_count;
    ctrl_t              w_ctrl;
    logic               w_active;
    logic               w_end;

    // Only the opcode steers control; the remaining ir bits serve the datapath.
    logic [INSTR_W-1:0] w_ir_unused;
    assign w_ir_unused = r_ir;

    ctrl_decode u_decode (
        .i_opcode (r_ir[OP_LSB +: 6]),
        .o_ctrl   (w_ctrl)
    );

    assign w_active = (r_state == ST_DECODE) || (r_state == ST_EXEC) ||
                      (r_state == ST_MEM)    || (r_state == ST_WB);

    assign Jump              = w_active & w_ctrl.jump;
    assign Branch            = w_active & w_ctrl.branch;
    assign Bne               = w_active & w_ctrl.bne;
    assign MemtoReg          = w_active & w_ctrl.mem_to_reg;
    assign source            = w_active & w_ctrl.source;
    assign instruction_check = w_active & w_ctrl.instr_check;
    assign Operation         = w_active ? w_ctrl.operation : 2'b00;
    assign illegal           = (r_state == ST_TRAP);
    assign instr_count       = r_count;

    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        instr_done   = 1'b0;
        w_end        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we        = 1'b1;
                    pc_we        = 1'b1;
                    w_state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state_next = w_ctrl.valid ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                case (w_ctrl.seq)
                    SEQ_ALU:   w_state_next = ST_WB;
                    SEQ_LOAD,
                    SEQ_STORE: w_state_next = ST_MEM;
                    default:   w_end        = 1'b1;
                endcase
                if (w_ctrl.jump ||
                    (w_ctrl.branch && branch_taken(w_ctrl.bne, zero))) begin
                    pc_we  = 1'b1;
                    pc_src = 1'b1;
                end
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                MemWrite = w_ctrl.mem_write;
                if (mem_ready) begin
                    if (w_ctrl.seq == SEQ_LOAD) w_state_next = ST_WB;
                    else                        w_end        = 1'b1;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                w_end    = 1'b1;
            end
            ST_TRAP: begin
                w_state_next = ST_TRAP;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (w_end) begin
            instr_done   = 1'b1;
            w_state_next = run ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ir    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (ir_we)      r_ir    <= mem_rdata;
            if (instr_done) r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control vectors for each
// instruction class, trap, mid-instruction reset and counter wrap.
module tb_multicycle_control;
    import bubble_ctrl_pkg::*;

    localparam int CW = 4;

    // Bit masks into the observed control vector.
    localparam logic [15:0] M_REQ  = 16'h8000;
    localparam logic [15:0] M_IRWE = 16'h4000;
    localparam logic [15:0] M_PCWE = 16'h2000;
    localparam logic [15:0] M_PCS  = 16'h1000;
    localparam logic [15:0] M_JMP  = 16'h0800;
    localparam logic [15:0] M_BR   = 16'h0400;
    localparam logic [15:0] M_BNE  = 16'h0200;
    localparam logic [15:0] M_M2R  = 16'h0100;
    localparam logic [15:0] M_MW   = 16'h0080;
    localparam logic [15:0] M_SRC  = 16'h0040;
    localparam logic [15:0] M_RW   = 16'h0020;
    localparam logic [15:0] M_ICHK = 16'h0010;
    localparam logic [15:0] M_OP11 = 16'h000C;
    localparam logic [15:0] M_OP10 = 16'h0008;
    localparam logic [15:0] M_OP01 = 16'h0004;
    localparam logic [15:0] M_ILL  = 16'h0002;
    localparam logic [15:0] M_DONE = 16'h0001;
    localparam logic [15:0] E_FETCH = M_REQ | M_IRWE | M_PCWE;

    logic          clk = 1'b0;
    logic          rst, run, mem_ready, zero;
    logic [31:0]   mem_rdata;
    logic          mem_req, ir_we, pc_we, Jump, Branch, Bne, MemtoReg, MemWrite;
    logic          source, RegWrite, instruction_check, pc_src, illegal, instr_done;
    logic [1:0]    Operation;
    logic [CW-1:0] instr_count;
    logic [15:0]   w_obs;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.INSTR_W(32), .OP_LSB(26), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .zero(zero), .mem_req(mem_req), .ir_we(ir_we),
        .pc_we(pc_we), .Jump(Jump), .Branch(Branch), .Bne(Bne),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .source(source),
        .RegWrite(RegWrite), .instruction_check(instruction_check),
        .Operation(Operation), .pc_src(pc_src), .illegal(illegal),
        .instr_done(instr_done), .instr_count(instr_count)
    );

    assign w_obs = {mem_req, ir_we, pc_we, pc_src, Jump, Branch, Bne, MemtoReg,
                    MemWrite, source, RegWrite, instruction_check, Operation,
                    illegal, instr_done};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; mem_ready = 1'b1; zero = 1'b0; mem_rdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (w_obs !== 16'h0) $display("FAIL reset_outputs: got %h want %h", w_obs, 16'h0);
        else n_pass++;
        n_checks++;
        if (instr_count !== 4'd0) $display("FAIL reset_count: got %0d want 0", instr_count);
        else n_pass++;
        tick();
        n_checks++;
        if (dut.r_state !== ST_IDLE || w_obs !== 16'h0)
            $display("FAIL idle_ignores_ready: state %0d obs %h want state 0 obs 0000", dut.r_state, w_obs);
        else n_pass++;
        $display("reset: obs=%h count=%0d", w_obs, instr_count);
    endtask

    task automatic test_rtype();
        logic [15:0] exp [4];
        exp = '{E_FETCH, M_OP10, M_OP10, M_OP10 | M_RW | M_DONE};
        mem_rdata = 32'h012A4020; mem_ready = 1'b1; run = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 1) run = 1'b0;
            #1;
            n_checks++;
            if (w_obs !== exp[c]) $display("FAIL rtype_cyc%0d: got %h want %h", c + 1, w_obs, exp[c]);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (instr_count !== 4'd1 || w_obs !== 16'h0)
            $display("FAIL rtype_end: count %0d obs %h want 1 and 0000", instr_count, w_obs);
        else n_pass++;
        $display("R 012A4020: count=%0d", instr_count);
    endtask

    task automatic test_lw_wait();
        logic [15:0] e;
        logic [15:0] exp [8];
        logic        rdy [8];
        e = M_ICHK | M_SRC | M_M2R;
        exp = '{E_FETCH, e, e, M_REQ | e, M_REQ | e, M_REQ | e, M_REQ | e, e | M_RW | M_DONE};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        mem_rdata = 32'h8D090004; mem_ready = 1'b1; run = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            if (c == 1) run = 1'b0;
            mem_ready = rdy[c];
            #1;
            n_checks++;
            if (w_obs !== exp[c]) $display("FAIL lw_cyc%0d: got %h want %h", c + 1, w_obs, exp[c]);
            else n_pass++;
            tick();
        end
        mem_ready = 1'b1;
        n_checks++;
        if (instr_count !== 4'd2 || w_obs !== 16'h0)
            $display("FAIL lw_end: count %0d obs %h want 2 and 0000", instr_count, w_obs);
        else n_pass++;
        $display("LW 8D090004 (3 wait cycles): count=%0d", instr_count);
    endtask

    task automatic test_branch();
        logic [31:0] instr [2];
        logic [15:0] exp [2][3];
        instr = '{32'h11090003, 32'h15090003};
        exp[0] = '{E_FETCH, M_ICHK | M_BR | M_OP01,
                   M_ICHK | M_BR | M_OP01 | M_PCWE | M_PCS | M_DONE};
        exp[1] = '{E_FETCH, M_ICHK | M_BR | M_BNE | M_OP01,
                   M_ICHK | M_BR | M_BNE | M_OP01 | M_DONE};
        zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_rdata = instr[i]; mem_ready = 1'b1; run = 1'b1;
            tick();
            for (int c = 0; c < 3; c++) begin
                if (c == 1) run = 1'b0;
                #1;
                n_checks++;
                if (w_obs !== exp[i][c])
                    $display("FAIL branch%0d_cyc%0d: got %h want %h", i, c + 1, w_obs, exp[i][c]);
                else n_pass++;
                tick();
            end
            n_checks++;
            if (instr_count !== 4'(3 + i))
                $display("FAIL branch%0d_count: got %0d want %0d", i, instr_count, 3 + i);
            else n_pass++;
            $display("branch %h zero=1: count=%0d", instr[i], instr_count);
        end
        zero = 1'b0;
    endtask

    task automatic test_trap();
        mem_rdata = 32'hFC000000; mem_ready = 1'b1; run = 1'b1;
        tick();
        run = 1'b0;
        #1;
        n_checks++;
        if (w_obs !== E_FETCH) $display("FAIL trap_fetch: got %h want %h", w_obs, E_FETCH);
        else n_pass++;
        tick();
        n_checks++;
        if (w_obs !== 16'h0) $display("FAIL trap_decode: got %h want %h", w_obs, 16'h0);
        else n_pass++;
        run = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (w_obs !== M_ILL || instr_count !== 4'd4)
                $display("FAIL trap_hold%0d: obs %h count %0d want %h and 4", c, w_obs, instr_count, M_ILL);
            else n_pass++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0;
        #1;
        n_checks++;
        if (dut.r_state !== ST_IDLE || w_obs !== 16'h0 || instr_count !== 4'd0)
            $display("FAIL trap_reset: state %0d obs %h count %0d want 0/0000/0", dut.r_state, w_obs, instr_count);
        else n_pass++;
        $display("opcode 111111: trapped, cleared by rst");
    endtask

    task automatic test_sw_reset();
        logic [15:0] expj [3];
        logic [15:0] exps [4];
        logic        rdys [4];
        expj = '{E_FETCH, M_ICHK | M_JMP | M_OP01, M_ICHK | M_JMP | M_OP01 | M_PCWE | M_PCS | M_DONE};
        exps = '{E_FETCH, M_ICHK | M_SRC, M_ICHK | M_SRC, M_REQ | M_ICHK | M_SRC | M_MW};
        rdys = '{1'b1, 1'b1, 1'b0, 1'b0};
        mem_rdata = 32'h08000010; mem_ready = 1'b1; run = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            if (c == 1) run = 1'b0;
            #1;
            n_checks++;
            if (w_obs !== expj[c]) $display("FAIL jump_cyc%0d: got %h want %h", c + 1, w_obs, expj[c]);
            else n_pass++;
            tick();
        end
        $display("J 08000010: count=%0d", instr_count);
        mem_rdata = 32'hAD090008; run = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 1) run = 1'b0;
            mem_ready = rdys[c];
            #1;
            n_checks++;
            if (w_obs !== exps[c]) $display("FAIL sw_cyc%0d: got %h want %h", c + 1, w_obs, exps[c]);
            else n_pass++;
            if (c < 3) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        n_checks++;
        if (dut.r_state !== ST_IDLE || w_obs !== 16'h0 || instr_count !== 4'd0)
            $display("FAIL sw_reset: state %0d obs %h count %0d want 0/0000/0", dut.r_state, w_obs, instr_count);
        else n_pass++;
        tick();
        n_checks++;
        if (w_obs !== 16'h0) $display("FAIL sw_after_reset: got %h want %h", w_obs, 16'h0);
        else n_pass++;
        $display("SW AD090008: reset in MEM, count=%0d", instr_count);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [4];
        exp = '{E_FETCH, M_ICHK | M_SRC, M_ICHK | M_SRC, M_ICHK | M_SRC | M_RW | M_DONE};
        mem_rdata = 32'h21290001; mem_ready = 1'b1; run = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (k == 15 && c == 3) run = 1'b0;
                #1;
                n_checks++;
                if (w_obs !== exp[c]) $display("FAIL addi%0d_cyc%0d: got %h want %h", k, c + 1, w_obs, exp[c]);
                else n_pass++;
                if (c == 3) begin
                    n_checks++;
                    if (instr_count !== 4'(k))
                        $display("FAIL addi%0d_count: got %0d want %0d", k, instr_count, k);
                    else n_pass++;
                end
                tick();
            end
            $display("ADDI #%0d retired", k);
        end
        #1;
        n_checks++;
        if (instr_count !== 4'd0 || dut.r_state !== ST_IDLE || w_obs !== 16'h0)
            $display("FAIL wrap_end: count %0d state %0d obs %h want 0/0/0000", instr_count, dut.r_state, w_obs);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch();
        test_trap();
        test_sw_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
